// File: rtl/sprite_motion_ctrl_if.sv
// Corner-probe handshake between the sprite motion sequencer and the wall lookup.
// The master presents a coordinate with valid; the slave answers with ack and wall.
interface sprite_motion_ctrl_if;
    logic       probe_valid;
    logic [9:0] probe_x;
    logic [9:0] probe_y;
    logic       probe_ack;
    logic       probe_wall;

    modport master (
        output probe_valid, probe_x, probe_y,
        input  probe_ack, probe_wall
    );

    modport slave (
        input  probe_valid, probe_x, probe_y,
        output probe_ack, probe_wall
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Frame-paced sprite motion sequencer: clamps a candidate step, probes its four
// corners against the wall lookup, then commits or rejects the move.
module sprite_motion_ctrl #(
    parameter logic [9:0] START_X   = 10'd6,
    parameter logic [9:0] START_Y   = 10'd406,
    parameter logic [9:0] SPR_W     = 10'd70,
    parameter logic [9:0] SPR_H     = 10'd70,
    parameter logic [9:0] STEP      = 10'd2,
    parameter logic [3:0] FRAME_DIV = 4'd1,
    parameter logic [9:0] X_MIN     = 10'd6,
    parameter logic [9:0] X_MAX     = 10'd635,
    parameter logic [9:0] Y_MIN     = 10'd6,
    parameter logic [9:0] Y_MAX     = 10'd475
) (
    input  logic                        pclk,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic [3:0]                  dir_req,
    sprite_motion_ctrl_if.master        prb,
    output logic [9:0]                  pos_x,
    output logic [9:0]                  pos_y,
    output logic                        busy,
    output logic                        moved,
    output logic                        blocked,
    output logic                        overrun
);

    localparam logic [10:0] L_STEP  = {1'b0, STEP};
    localparam logic [10:0] L_SPR_W = {1'b0, SPR_W};
    localparam logic [10:0] L_SPR_H = {1'b0, SPR_H};
    localparam logic [10:0] L_X_MIN = {1'b0, X_MIN};
    localparam logic [10:0] L_X_MAX = {1'b0, X_MAX};
    localparam logic [10:0] L_Y_MIN = {1'b0, Y_MIN};
    localparam logic [10:0] L_Y_MAX = {1'b0, Y_MAX};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_PROBE, S_COMMIT} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t     r_state;
    dir_t       r_dir;
    dir_t       w_dir;
    logic [3:0] r_cnt;
    logic [1:0] r_corner;
    logic [1:0] w_next_corner;
    logic [9:0] r_pos_x, r_pos_y;
    logic [9:0] r_cx, r_cy;
    logic [9:0] r_px, r_py;
    logic [9:0] w_cx, w_cy;
    logic [9:0] w_nx, w_ny;
    logic       r_valid, r_moved, r_blocked, r_overrun;
    logic       w_accept;

    always_comb begin
        w_dir = D_RIGHT;
        if (dir_req[3])      w_dir = D_UP;
        else if (dir_req[2]) w_dir = D_DOWN;
        else if (dir_req[1]) w_dir = D_LEFT;
    end

    // Bound tests run in 11 bits so y+STEP+SPR_H-1 can exceed 1023 without wrapping.
    always_comb begin
        w_cx = r_pos_x;
        w_cy = r_pos_y;
        case (r_dir)
            D_UP:    w_cy = ({1'b0, r_pos_y} < L_Y_MIN + L_STEP) ? Y_MIN : r_pos_y - STEP;
            D_DOWN:  w_cy = ({1'b0, r_pos_y} + L_STEP + L_SPR_H - 11'd1 > L_Y_MAX)
                            ? Y_MAX - SPR_H + 10'd1 : r_pos_y + STEP;
            D_LEFT:  w_cx = ({1'b0, r_pos_x} < L_X_MIN + L_STEP) ? X_MIN : r_pos_x - STEP;
            D_RIGHT: w_cx = ({1'b0, r_pos_x} + L_STEP + L_SPR_W - 11'd1 > L_X_MAX)
                            ? X_MAX - SPR_W + 10'd1 : r_pos_x + STEP;
            default: ;
        endcase
    end

    always_comb begin
        w_next_corner = r_corner + 2'd1;
        w_nx          = r_cx + (w_next_corner[0] ? SPR_W - 10'd1 : '0);
        w_ny          = r_cy + (w_next_corner[1] ? SPR_H - 10'd1 : '0);
        w_accept      = (r_cnt == FRAME_DIV - 4'd1);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dir     <= D_RIGHT;
            r_cnt     <= '0;
            r_corner  <= '0;
            r_pos_x   <= START_X;
            r_pos_y   <= START_Y;
            r_cx      <= START_X;
            r_cy      <= START_Y;
            r_px      <= '0;
            r_py      <= '0;
            r_valid   <= 1'b0;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
            r_overrun <= frame_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        if (w_accept) begin
                            r_cnt <= '0;
                            if (dir_req != 4'd0) begin
                                r_dir   <= w_dir;
                                r_state <= S_CALC;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_CALC: begin
                    if (w_cx == r_pos_x && w_cy == r_pos_y) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cx     <= w_cx;
                        r_cy     <= w_cy;
                        r_px     <= w_cx;
                        r_py     <= w_cy;
                        r_corner <= '0;
                        r_valid  <= 1'b1;
                        r_state  <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (r_valid && prb.probe_ack) begin
                        if (prb.probe_wall) begin
                            r_valid   <= 1'b0;
                            r_blocked <= 1'b1;
                            r_state   <= S_IDLE;
                        end else if (r_corner == 2'd3) begin
                            r_valid <= 1'b0;
                            r_state <= S_COMMIT;
                        end else begin
                            r_corner <= w_next_corner;
                            r_px     <= w_nx;
                            r_py     <= w_ny;
                        end
                    end
                end
                S_COMMIT: begin
                    r_pos_x <= r_cx;
                    r_pos_y <= r_cy;
                    r_moved <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign prb.probe_valid = r_valid;
    assign prb.probe_x     = r_px;
    assign prb.probe_y     = r_py;
    assign pos_x           = r_pos_x;
    assign pos_y           = r_pos_y;
    assign busy            = (r_state != S_IDLE);
    assign moved           = r_moved;
    assign blocked         = r_blocked;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus pushes expected probes and
// outcomes from a plain-arithmetic model; monitors pop and compare.
module tb_sprite_motion_ctrl;

    localparam int X_MIN = 6, X_MAX = 635, Y_MIN = 6, Y_MAX = 475;
    localparam int W = 70, H = 70, STEP = 2;

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic       tick1 = 1'b0, tick2 = 1'b0;
    logic [3:0] dir1 = '0, dir2 = '0;
    logic [9:0] pos_x1, pos_y1, pos_x2, pos_y2;
    logic       busy1, moved1, blocked1, overrun1;
    logic       busy2, moved2, blocked2, overrun2;

    sprite_motion_ctrl_if prb1();
    sprite_motion_ctrl_if prb2();

    always #5 pclk = ~pclk;

    sprite_motion_ctrl dut1 (
        .pclk(pclk), .rst(rst), .frame_tick(tick1), .dir_req(dir1), .prb(prb1),
        .pos_x(pos_x1), .pos_y(pos_y1), .busy(busy1), .moved(moved1),
        .blocked(blocked1), .overrun(overrun1)
    );

    sprite_motion_ctrl #(.START_X(10'd561), .FRAME_DIV(4'd3)) dut2 (
        .pclk(pclk), .rst(rst), .frame_tick(tick2), .dir_req(dir2), .prb(prb2),
        .pos_x(pos_x2), .pos_y(pos_y2), .busy(busy2), .moved(moved2),
        .blocked(blocked2), .overrun(overrun2)
    );

    assign prb2.probe_ack  = 1'b1;
    assign prb2.probe_wall = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_cand(input int x, input int y, input logic [3:0] d,
                                       output int cx, output int cy);
        cx = x;
        cy = y;
        if (d[3])      cy = (y - STEP < Y_MIN) ? Y_MIN : y - STEP;
        else if (d[2]) cy = (y + STEP > Y_MAX - H + 1) ? Y_MAX - H + 1 : y + STEP;
        else if (d[1]) cx = (x - STEP < X_MIN) ? X_MIN : x - STEP;
        else if (d[0]) cx = (x + STEP > X_MAX - W + 1) ? X_MAX - W + 1 : x + STEP;
    endfunction

    // scoreboard state
    int ex_px[$], ex_py[$];
    int ex_kind[$], ex_ox[$], ex_oy[$];   // kind 1 = moved, 2 = blocked
    int m_x = 6, m_y = 406, m_cnt = 0, m_ovr = 0, ovr_seen = 0;

    // responder controls
    int  ack_delay = 0, wall_corner = 4, hold_corner = 4, resp_idx = 0, wcnt = 0;

    initial begin
        prb1.probe_ack  = 1'b0;
        prb1.probe_wall = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (prb1.probe_valid) begin
                if (resp_idx < hold_corner && wcnt >= ack_delay) begin
                    prb1.probe_ack  = 1'b1;
                    prb1.probe_wall = (resp_idx == wall_corner);
                    resp_idx++;
                    wcnt = 0;
                end else begin
                    prb1.probe_ack  = 1'b0;
                    prb1.probe_wall = 1'($urandom % 2);
                    wcnt++;
                end
            end else begin
                prb1.probe_ack  = 1'($urandom % 2);
                prb1.probe_wall = 1'($urandom % 2);
                resp_idx = 0;
                wcnt     = 0;
            end
        end
    end

    // dut1 monitor
    logic prev_wait = 1'b0;
    int   hold_x = 0, hold_y = 0;
    initial begin
        forever begin
            @(negedge pclk);
            if (prb1.probe_valid && prb1.probe_ack) begin
                chk("probe_expected", int'(ex_px.size() > 0), 1);
                if (ex_px.size() > 0) begin
                    chk("probe_x", prb1.probe_x, ex_px.pop_front());
                    chk("probe_y", prb1.probe_y, ex_py.pop_front());
                end
            end
            if (prev_wait && prb1.probe_valid) begin
                chk("probe_x_stable", prb1.probe_x, hold_x);
                chk("probe_y_stable", prb1.probe_y, hold_y);
            end
            prev_wait = prb1.probe_valid && !prb1.probe_ack;
            hold_x    = prb1.probe_x;
            hold_y    = prb1.probe_y;
            if (moved1 || blocked1) begin
                chk("outcome_expected", int'(ex_kind.size() > 0), 1);
                if (ex_kind.size() > 0) begin
                    chk("outcome_kind", moved1 ? 1 : 2, ex_kind.pop_front());
                    chk("outcome_pos_x", pos_x1, ex_ox.pop_front());
                    chk("outcome_pos_y", pos_y1, ex_oy.pop_front());
                end
            end
            if (overrun1) ovr_seen++;
        end
    end

    // dut2 monitor
    int p2_cnt = 0, mv2_cnt = 0;
    initial begin
        forever begin
            @(negedge pclk);
            if (prb2.probe_valid && prb2.probe_ack) p2_cnt++;
            if (moved2) mv2_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        m_x   = 6;
        m_y   = 406;
        m_cnt = 0;
    endtask

    task automatic attempt(input logic [3:0] d, input int dly, input int wc, input int extra_in);
        int cx, cy, exp_lat, lat_seen, cyc, extra_at;
        bit acc;
        ack_delay   = dly;
        wall_corner = wc;
        hold_corner = 4;
        exp_lat     = -1;
        extra_at    = extra_in;
        acc = (m_cnt == 0);          // FRAME_DIV = 1 on dut1
        if (acc && d != 4'd0) begin
            model_cand(m_x, m_y, d, cx, cy);
            if (cx != m_x || cy != m_y) begin
                for (int k = 0; k < 4; k++) begin
                    if (k <= wc) begin
                        ex_px.push_back(cx + (k % 2) * (W - 1));
                        ex_py.push_back(cy + (k / 2) * (H - 1));
                    end
                end
                if (wc < 4) begin
                    ex_kind.push_back(2); ex_ox.push_back(m_x); ex_oy.push_back(m_y);
                    exp_lat = (wc + 1) * (dly + 1) + 1;
                end else begin
                    ex_kind.push_back(1); ex_ox.push_back(cx); ex_oy.push_back(cy);
                    exp_lat = 6 + 4 * dly;
                    m_x = cx;
                    m_y = cy;
                end
            end
        end
        if (!(exp_lat > 0 && extra_at >= 0 && extra_at < exp_lat)) extra_at = -1;
        if (extra_at >= 0) m_ovr++;
        @(negedge pclk);
        tick1 = 1'b1;
        dir1  = d;
        @(negedge pclk);
        tick1    = 1'b0;
        cyc      = 0;
        lat_seen = -1;
        while (cyc < 200) begin
            if ((moved1 || blocked1) && lat_seen < 0) lat_seen = cyc;
            if (!busy1) break;
            tick1 = (cyc == extra_at);
            @(negedge pclk);
            cyc++;
        end
        tick1 = 1'b0;
        #2;
        chk("idle_within_bound", int'(cyc < 200), 1);
        chk("pulse_latency", lat_seen, exp_lat);
        chk("pos_x", pos_x1, m_x);
        chk("pos_y", pos_y1, m_y);
        chk("overrun_count", ovr_seen, m_ovr);
    endtask

    initial begin
        int cx, cy, s_p, s_m, n;
        bit acc, mv;
        int m2_x, m2_y, m2_cnt;
        logic [3:0] d;

        do_reset();
        #1;
        chk("rst_pos_x", pos_x1, 6);
        chk("rst_pos_y", pos_y1, 406);
        chk("rst_valid", prb1.probe_valid, 0);
        chk("rst_probe_x", prb1.probe_x, 0);
        chk("rst_probe_y", prb1.probe_y, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_pulses", {moved1, blocked1, overrun1}, 0);
        chk("rst2_pos_x", pos_x2, 561);

        // dut2: divider of 3, right clamp at 566, then up wins over right
        m2_x = 561; m2_y = 406; m2_cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            d   = (i <= 12) ? 4'b0001 : 4'b1001;
            acc = (m2_cnt == 2);
            m2_cnt = acc ? 0 : m2_cnt + 1;
            mv = 1'b0;
            if (acc) begin
                model_cand(m2_x, m2_y, d, cx, cy);
                mv   = (cx != m2_x || cy != m2_y);
                m2_x = cx;
                m2_y = cy;
            end
            s_p = p2_cnt;
            s_m = mv2_cnt;
            @(negedge pclk);
            tick2 = 1'b1;
            dir2  = d;
            @(negedge pclk);
            tick2 = 1'b0;
            repeat (12) @(negedge pclk);
            #1;
            chk("div_probes", p2_cnt - s_p, mv ? 4 : 0);
            chk("div_moves", mv2_cnt - s_m, mv ? 1 : 0);
            chk("div_pos_x", pos_x2, m2_x);
            chk("div_pos_y", pos_y2, m2_y);
            chk("div_busy", busy2, 0);
        end

        // first move, zero-wait ack
        attempt(4'b0001, 0, 4, -1);
        // right move with wall on corner 1
        do_reset();
        attempt(4'b0001, 0, 1, -1);

        // reset during corner 2 with ack held low
        do_reset();
        hold_corner = 2;
        ack_delay   = 0;
        wall_corner = 4;
        ex_px.push_back(8);  ex_py.push_back(406);
        ex_px.push_back(77); ex_py.push_back(406);
        @(negedge pclk);
        tick1 = 1'b1;
        dir1  = 4'b0001;
        @(negedge pclk);
        tick1 = 1'b0;
        n = 0;
        while (n < 50 && !(prb1.probe_valid && !prb1.probe_ack && resp_idx == 2)) begin
            @(negedge pclk);
            n++;
        end
        chk("reached_corner2", int'(n < 50), 1);
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        #1;
        chk("midrst_valid", prb1.probe_valid, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_pos_x", pos_x1, 6);
        chk("midrst_pos_y", pos_y1, 406);
        chk("midrst_pulses", {moved1, blocked1}, 0);
        rst = 1'b0;
        m_x = 6; m_y = 406; m_cnt = 0;
        hold_corner = 4;
        chk("midrst_probes_left", ex_px.size(), 0);

        // three-cycle ack waits with a second tick while busy
        attempt(4'b0001, 3, 4, 3);

        for (int i = 0; i < 60; i++) begin
            attempt(4'($urandom % 16), int'($urandom % 3),
                    ($urandom % 4 == 0) ? int'($urandom % 4) : 4,
                    ($urandom % 4 == 0) ? int'(1 + $urandom % 3) : -1);
        end

        repeat (4) @(negedge pclk);
        chk("probe_queue_empty", ex_px.size(), 0);
        chk("outcome_queue_empty", ex_kind.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
